secuenciador_multdiv: RTL and testbench

Iterative multiply/divide sequencer that sits beside the EX stage, owns the HI/LO register pair, and stalls the pipeline while a MULT/MULTU/DIV/DIVU instruction is in EX. It accepts one operation per request and runs a 32-step shift-add multiply or restoring divide. It holds the instruction in EX through `ocupado` and writes HI/LO when done. The single-cycle ALU path is unaffected; this block only sequences the multi-cycle resource.

---
 rtl/secuenciador_multdiv_if.sv | 22 ++
 rtl/secuenciador_multdiv.sv | 92 +++++++++
 tb/tb_secuenciador_multdiv.sv | 129 ++++++++++++
 3 files changed

// File: rtl/secuenciador_multdiv_if.sv
// secuenciador_multdiv_if: EX-stage handshake and HI/LO bus between the pipeline and the mult/div sequencer
//   iniciar_EX, operacion_md_EX, entrada_a_EX, entrada_b_EX : pipeline -> sequencer
//   ocupado, listo, error_div0, hi, lo                      : sequencer -> pipeline
interface secuenciador_multdiv_if #(parameter int ANCHO = 32);
    logic             iniciar_EX;
    logic [1:0]       operacion_md_EX;
    logic [ANCHO-1:0] entrada_a_EX;
    logic [ANCHO-1:0] entrada_b_EX;
    logic             ocupado;
    logic             listo;
    logic             error_div0;
    logic [ANCHO-1:0] hi;
    logic [ANCHO-1:0] lo;
    modport master (
        output iniciar_EX, operacion_md_EX, entrada_a_EX, entrada_b_EX,
        input  ocupado, listo, error_div0, hi, lo
    );
    modport slave (
        input  iniciar_EX, operacion_md_EX, entrada_a_EX, entrada_b_EX,
        output ocupado, listo, error_div0, hi, lo
    );
endinterface

// File: rtl/secuenciador_multdiv.sv
// secuenciador_multdiv: iterative MULT/MULTU/DIV/DIVU sequencer owning HI/LO, stalls EX while busy
//   clk, reset : clock and asynchronous active-high reset
//   md         : slave side of secuenciador_multdiv_if (request, operands, ocupado/listo, error_div0, hi/lo)
module secuenciador_multdiv #(
    parameter int ANCHO = 32
) (
    input logic                   clk,
    input logic                   reset,
    secuenciador_multdiv_if.slave md
);
    localparam int CW = $clog2(ANCHO);
    typedef enum logic [1:0] {IDLE, CALC, DONE} estado_t;
    estado_t            estado;
    logic [CW-1:0]      contador;
    logic               es_div, neg_q, neg_r, div0;
    logic [ANCHO-1:0]   operando_b;
    // upper half: multiply partial sum / divide remainder; lower half: multiplier / dividend-quotient
    logic [2*ANCHO-1:0] acc;
    logic               con_signo, signo_a, signo_b;
    logic [ANCHO-1:0]   a_abs, b_abs;
    logic [ANCHO:0]     suma, rem_sh, resta;
    logic [2*ANCHO-1:0] paso_mul, paso_div, prod_fin;
    logic [ANCHO-1:0]   hi_fin, lo_fin;
    always_comb begin
        con_signo = !md.operacion_md_EX[0];
        signo_a   = con_signo && md.entrada_a_EX[ANCHO-1];
        signo_b   = con_signo && md.entrada_b_EX[ANCHO-1];
        a_abs     = signo_a ? -md.entrada_a_EX : md.entrada_a_EX;
        b_abs     = signo_b ? -md.entrada_b_EX : md.entrada_b_EX;
        suma      = {1'b0, acc[2*ANCHO-1:ANCHO]} + (acc[0] ? {1'b0, operando_b} : '0);
        paso_mul  = {suma, acc[ANCHO-1:1]};
        rem_sh    = {acc[2*ANCHO-1:ANCHO], acc[ANCHO-1]};
        resta     = rem_sh - {1'b0, operando_b};
        // resta[ANCHO] is the borrow: keep the shifted remainder and shift in a 0 quotient bit
        paso_div  = {resta[ANCHO] ? rem_sh[ANCHO-1:0] : resta[ANCHO-1:0], acc[ANCHO-2:0], !resta[ANCHO]};
        prod_fin  = neg_q ? -acc : acc;
        hi_fin    = es_div ? (neg_r ? -acc[2*ANCHO-1:ANCHO] : acc[2*ANCHO-1:ANCHO]) : prod_fin[2*ANCHO-1:ANCHO];
        lo_fin    = es_div ? (neg_q ? -acc[ANCHO-1:0] : acc[ANCHO-1:0]) : prod_fin[ANCHO-1:0];
        md.ocupado = (estado == IDLE && md.iniciar_EX) || estado == CALC;
        md.listo   = estado == DONE;
    end
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            estado        <= IDLE;
            contador      <= '0;
            es_div        <= 1'b0;
            neg_q         <= 1'b0;
            neg_r         <= 1'b0;
            div0          <= 1'b0;
            operando_b    <= '0;
            acc           <= '0;
            md.hi         <= '0;
            md.lo         <= '0;
            md.error_div0 <= 1'b0;
        end else begin
            case (estado)
                IDLE: if (md.iniciar_EX) begin
                    es_div        <= md.operacion_md_EX[1];
                    operando_b    <= b_abs;
                    contador      <= '0;
                    md.error_div0 <= 1'b0;
                    if (md.operacion_md_EX[1] && md.entrada_b_EX == '0) begin
                        // divide by zero: HI gets the raw dividend, LO all ones, no sign fix-up
                        acc    <= {md.entrada_a_EX, {ANCHO{1'b1}}};
                        neg_q  <= 1'b0;
                        neg_r  <= 1'b0;
                        div0   <= 1'b1;
                        estado <= DONE;
                    end else begin
                        acc    <= {{ANCHO{1'b0}}, a_abs};
                        neg_q  <= signo_a ^ signo_b;
                        neg_r  <= signo_a;
                        div0   <= 1'b0;
                        estado <= CALC;
                    end
                end
                CALC: begin
                    acc      <= es_div ? paso_div : paso_mul;
                    contador <= contador + 1'b1;
                    if (contador == CW'(ANCHO-1)) estado <= DONE;
                end
                DONE: begin
                    md.hi         <= hi_fin;
                    md.lo         <= lo_fin;
                    md.error_div0 <= div0;
                    estado        <= IDLE;
                end
                default: estado <= IDLE;
            endcase
        end
    end
endmodule

// File: tb/tb_secuenciador_multdiv.sv
// tb_secuenciador_multdiv: scoreboard bench for secuenciador_multdiv with directed vectors
module tb_secuenciador_multdiv;
    localparam int ANCHO = 32;
    typedef struct packed {
        logic [31:0] hi;
        logic [31:0] lo;
        logic        err;
    } esperado_t;
    logic clk = 1'b0;
    logic reset;
    esperado_t cola[$];
    int n_vec = 0;
    int n_err = 0;
    always #5 clk = ~clk;
    secuenciador_multdiv_if #(.ANCHO(ANCHO)) md ();
    secuenciador_multdiv #(.ANCHO(ANCHO)) dut (.clk(clk), .reset(reset), .md(md.slave));
    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %h expected %h", name, act, exp);
        end
    endtask
    initial forever begin
        @(negedge clk);
        if (md.listo === 1'b1) begin
            esperado_t e;
            @(negedge clk);
            check("listo_one_cycle", 32'(md.listo), 32'd0);
            if (cola.size() == 0) begin
                n_vec++;
                n_err++;
                $display("FAIL unexpected_completion: got hi=%h lo=%h with no pending op", md.hi, md.lo);
            end else begin
                e = cola.pop_front();
                check("hi", md.hi, e.hi);
                check("lo", md.lo, e.lo);
                check("error_div0", 32'(md.error_div0), 32'(e.err));
            end
        end
    end
    task automatic run_op(input string name, input logic [1:0] op, input logic [31:0] a, input logic [31:0] b,
                          input logic [31:0] ehi, input logic [31:0] elo, input logic eerr, input int estall,
                          input bit hold);
        int cnt = 0;
        esperado_t e;
        e.hi = ehi;
        e.lo = elo;
        e.err = eerr;
        cola.push_back(e);
        @(negedge clk); #1;
        md.iniciar_EX = 1'b1;
        md.operacion_md_EX = op;
        md.entrada_a_EX = a;
        md.entrada_b_EX = b;
        #1;
        while (md.ocupado === 1'b1 && cnt < 100) begin
            cnt++;
            if (cnt == 2) begin
                check({name, "_err_cleared"}, 32'(md.error_div0), 32'd0);
                md.entrada_a_EX = ~a;
                md.entrada_b_EX = ~b;
            end
            @(negedge clk); #1;
        end
        check({name, "_stall_cycles"}, 32'(cnt), 32'(estall));
        if (hold) begin
            @(posedge clk); #1;
            md.iniciar_EX = 1'b0;
            #1 check({name, "_no_restart"}, 32'(md.ocupado), 32'd0);
            repeat (3) @(negedge clk);
        end else begin
            md.iniciar_EX = 1'b0;
        end
    endtask
    initial begin
        reset = 1'b1;
        md.iniciar_EX = 1'b0;
        md.operacion_md_EX = 2'b00;
        md.entrada_a_EX = '0;
        md.entrada_b_EX = '0;
        @(negedge clk); #1;
        check("reset_hi", md.hi, 32'd0);
        check("reset_lo", md.lo, 32'd0);
        check("reset_err", 32'(md.error_div0), 32'd0);
        check("reset_listo", 32'(md.listo), 32'd0);
        md.iniciar_EX = 1'b1;
        #1 check("reset_ocupado_follows", 32'(md.ocupado), 32'd1);
        md.iniciar_EX = 1'b0;
        #1 check("reset_ocupado_low", 32'(md.ocupado), 32'd0);
        reset = 1'b0;
        run_op("multu_max", 2'b01, 32'hFFFFFFFF, 32'hFFFFFFFF, 32'hFFFFFFFE, 32'h00000001, 1'b0, 33, 1'b0);
        run_op("mult_m3x7", 2'b00, 32'hFFFFFFFD, 32'd7, 32'hFFFFFFFF, 32'hFFFFFFEB, 1'b0, 33, 1'b0);
        run_op("div_m7d2", 2'b10, 32'hFFFFFFF9, 32'd2, 32'hFFFFFFFF, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
        run_op("divu_100d7", 2'b11, 32'd100, 32'd7, 32'd2, 32'd14, 1'b0, 33, 1'b0);
        run_op("divu_5d0", 2'b11, 32'd5, 32'd0, 32'd5, 32'hFFFFFFFF, 1'b1, 1, 1'b0);
        run_op("multu_3x5", 2'b01, 32'd3, 32'd5, 32'd0, 32'd15, 1'b0, 33, 1'b0);
        run_op("div_ovf", 2'b10, 32'h80000000, 32'hFFFFFFFF, 32'd0, 32'h80000000, 1'b0, 33, 1'b0);
        run_op("mult_minsq", 2'b00, 32'h80000000, 32'h80000000, 32'h40000000, 32'd0, 1'b0, 33, 1'b0);
        run_op("div_m5d0", 2'b10, 32'hFFFFFFFB, 32'd0, 32'hFFFFFFFB, 32'hFFFFFFFF, 1'b1, 1, 1'b0);
        run_op("multu_shift", 2'b01, 32'h12345678, 32'h10, 32'h1, 32'h23456780, 1'b0, 33, 1'b0);
        run_op("div_7dm2", 2'b10, 32'd7, 32'hFFFFFFFE, 32'd1, 32'hFFFFFFFD, 1'b0, 33, 1'b0);
        // reset in the middle of a divide: nothing pushed, nothing may complete
        @(negedge clk); #1;
        md.iniciar_EX = 1'b1;
        md.operacion_md_EX = 2'b10;
        md.entrada_a_EX = 32'hFFFFFF9C;
        md.entrada_b_EX = 32'd3;
        repeat (11) @(negedge clk);
        #2;
        md.iniciar_EX = 1'b0;
        reset = 1'b1;
        #1;
        check("midreset_ocupado", 32'(md.ocupado), 32'd0);
        check("midreset_listo", 32'(md.listo), 32'd0);
        check("midreset_hi", md.hi, 32'd0);
        check("midreset_lo", md.lo, 32'd0);
        check("midreset_err", 32'(md.error_div0), 32'd0);
        @(negedge clk); #1;
        reset = 1'b0;
        repeat (3) @(negedge clk);
        run_op("divu_after_reset", 2'b11, 32'hFFFFFFFF, 32'h10, 32'hF, 32'h0FFFFFFF, 1'b0, 33, 1'b0);
        run_op("mult_hold", 2'b00, 32'd2, 32'hFFFFFFFE, 32'hFFFFFFFF, 32'hFFFFFFFC, 1'b0, 33, 1'b1);
        repeat (5) @(negedge clk);
        check("scoreboard_empty", 32'(cola.size()), 32'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end
endmodule
